// File: rtl/mc_ctrl_if.sv
// Control-unit <-> datapath signal bundle. The master side is the control unit;
// the slave side is the datapath/memory that supplies Instruction and mem_ready.
interface mc_ctrl_if;
  logic [31:0] Instruction;
  logic        mem_ready;
  logic        Extop;
  logic        jal_sel;
  logic        ALUSrc;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic        RegWrite;
  logic        lb_sel;
  logic        sb_sel;
  logic [2:0]  ALUControl;
  logic [2:0]  Npc_op;
  logic        pc_en;
  logic        mem_req;
  logic        illegal;
  logic        mem_err;
  logic [31:0] instr_count;

  modport master (
    input  Instruction, mem_ready,
    output Extop, jal_sel, ALUSrc, MemWrite, MemtoReg, RegDst, RegWrite,
           lb_sel, sb_sel, ALUControl, Npc_op, pc_en, mem_req, illegal,
           mem_err, instr_count
  );

  modport slave (
    output Instruction, mem_ready,
    input  Extop, jal_sel, ALUSrc, MemWrite, MemtoReg, RegDst, RegWrite,
           lb_sel, sb_sel, ALUControl, Npc_op, pc_en, mem_req, illegal,
           mem_err, instr_count
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// wait-state tolerant data-memory handshake and a retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);
  localparam int unsigned WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
    K_LB, K_SB, K_BEQ, K_J, K_JAL, K_ILL
  } kind_t;

  state_t        r_state, w_next;
  kind_t         w_kind;
  logic [31:0]   r_ir;
  logic [31:0]   r_instr_count;
  logic [WW-1:0] r_wait;
  logic          r_illegal, r_mem_err;
  logic          w_is_load, w_is_store;
  logic          w_retire, w_timeout, w_wait_inc;
  logic          w_pc_en, w_regwrite, w_memwrite, w_mem_req;
  logic [6:0]    w_flags;  // {Extop, jal_sel, ALUSrc, MemtoReg, RegDst, lb_sel, sb_sel}
  logic [2:0]    w_alu, w_npc;

  always_comb begin
    w_kind = K_ILL;
    case (r_ir[31:26])
      6'h00: begin
        if (r_ir == '0) w_kind = K_NOP;
        else begin
          case (r_ir[5:0])
            6'h21:   w_kind = K_ADDU;
            6'h23:   w_kind = K_SUBU;
            6'h08:   w_kind = K_JR;
            default: w_kind = K_ILL;
          endcase
        end
      end
      6'h0D:   w_kind = K_ORI;
      6'h0F:   w_kind = K_LUI;
      6'h23:   w_kind = K_LW;
      6'h2B:   w_kind = K_SW;
      6'h20:   w_kind = K_LB;
      6'h28:   w_kind = K_SB;
      6'h04:   w_kind = K_BEQ;
      6'h02:   w_kind = K_J;
      6'h03:   w_kind = K_JAL;
      default: w_kind = K_ILL;
    endcase
  end

  assign w_is_load  = (w_kind == K_LW) || (w_kind == K_LB);
  assign w_is_store = (w_kind == K_SW) || (w_kind == K_SB);

  // Level controls come from ir alone and are held low while fetching.
  always_comb begin
    w_flags = '0;
    w_alu   = '0;
    w_npc   = '0;
    if (r_state != FETCH) begin
      case (w_kind)
        K_ADDU: w_flags = 7'b0000100;
        K_SUBU: begin w_flags = 7'b0000100; w_alu = 3'b001; end
        K_JR:   w_npc   = 3'b011;
        K_ORI:  begin w_flags = 7'b0010000; w_alu = 3'b010; end
        K_LUI:  begin w_flags = 7'b0010000; w_alu = 3'b011; end
        K_LW:   w_flags = 7'b1011000;
        K_LB:   w_flags = 7'b1011010;
        K_SW:   w_flags = 7'b1010000;
        K_SB:   w_flags = 7'b1010001;
        K_BEQ:  begin w_alu = 3'b001; w_npc = 3'b001; end
        K_J:    w_npc   = 3'b010;
        K_JAL:  begin w_flags = 7'b0100000; w_npc = 3'b010; end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pc_en    = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_mem_req  = 1'b0;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    w_wait_inc = 1'b0;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: w_next = EXEC;
      EXEC: begin
        if (w_is_load || w_is_store) w_next = MEM;
        else if (w_kind inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_JAL}) w_next = WB;
        else begin
          w_pc_en  = 1'b1;
          w_retire = 1'b1;
          w_next   = FETCH;
        end
      end
      MEM: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          if (w_is_load) w_next = WB;
          else begin
            w_memwrite = 1'b1;
            w_pc_en    = 1'b1;
            w_retire   = 1'b1;
            w_next     = FETCH;
          end
        end else if (r_wait == WW'(MEM_TIMEOUT - 1)) begin
          // Abandon the access: retire with no register or memory write.
          w_timeout = 1'b1;
          w_pc_en   = 1'b1;
          w_retire  = 1'b1;
          w_next    = FETCH;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      WB: begin
        w_regwrite = 1'b1;
        w_pc_en    = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir          <= '0;
      r_wait        <= '0;
      r_illegal     <= 1'b0;
      r_mem_err     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if (r_state == FETCH) r_ir <= bus.Instruction;
      r_wait <= w_wait_inc ? r_wait + 1'b1 : '0;
      if (r_state == DECODE && w_kind == K_ILL) r_illegal <= 1'b1;
      if (w_timeout) r_mem_err <= 1'b1;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign {bus.Extop, bus.jal_sel, bus.ALUSrc, bus.MemtoReg,
          bus.RegDst, bus.lb_sel, bus.sb_sel} = w_flags;
  assign bus.ALUControl  = w_alu;
  assign bus.Npc_op      = w_npc;
  assign bus.pc_en       = w_pc_en;
  assign bus.RegWrite    = w_regwrite;
  assign bus.MemWrite    = w_memwrite;
  assign bus.mem_req     = w_mem_req;
  assign bus.illegal     = r_illegal;
  assign bus.mem_err     = r_mem_err;
  assign bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios then random instructions, each cycle
// compared against a per-instruction schedule computed from the instruction class.
module tb_mc_ctrl;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;
  mc_ctrl_if bus();

  mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // cls: 0 = retire in EXEC, 1 = via WB, 2 = store, 3 = load
  typedef struct packed {
    logic [12:0] ctrl;
    logic [1:0]  cls;
    logic        ill;
  } exp_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic        exp_ill, exp_merr;
  logic [31:0] exp_cnt;

  function automatic exp_t mk(input logic [6:0] f, input logic [2:0] alu,
                              input logic [2:0] npc, input logic [1:0] cls);
    exp_t e;
    e.ctrl = {f, alu, npc};
    e.cls  = cls;
    e.ill  = 1'b0;
    return e;
  endfunction

  // Flag order: {Extop, jal_sel, ALUSrc, MemtoReg, RegDst, lb_sel, sb_sel}
  function automatic exp_t ref_decode(input logic [31:0] ins);
    logic [5:0] op, fn;
    exp_t e;
    op = ins[31:26];
    fn = ins[5:0];
    e  = '{ctrl: '0, cls: 2'd0, ill: 1'b1};
    if (ins == 32'd0)                e = mk(7'b0000000, 3'b000, 3'b000, 2'd0);
    else if (op == 6'h00 && fn == 6'h21) e = mk(7'b0000100, 3'b000, 3'b000, 2'd1);
    else if (op == 6'h00 && fn == 6'h23) e = mk(7'b0000100, 3'b001, 3'b000, 2'd1);
    else if (op == 6'h00 && fn == 6'h08) e = mk(7'b0000000, 3'b000, 3'b011, 2'd0);
    else if (op == 6'h0D) e = mk(7'b0010000, 3'b010, 3'b000, 2'd1);
    else if (op == 6'h0F) e = mk(7'b0010000, 3'b011, 3'b000, 2'd1);
    else if (op == 6'h23) e = mk(7'b1011000, 3'b000, 3'b000, 2'd3);
    else if (op == 6'h20) e = mk(7'b1011010, 3'b000, 3'b000, 2'd3);
    else if (op == 6'h2B) e = mk(7'b1010000, 3'b000, 3'b000, 2'd2);
    else if (op == 6'h28) e = mk(7'b1010001, 3'b000, 3'b000, 2'd2);
    else if (op == 6'h04) e = mk(7'b0000000, 3'b001, 3'b001, 2'd0);
    else if (op == 6'h02) e = mk(7'b0000000, 3'b000, 3'b010, 2'd0);
    else if (op == 6'h03) e = mk(7'b0100000, 3'b000, 3'b010, 2'd1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ctrl_vec();
    return 32'({bus.Extop, bus.jal_sel, bus.ALUSrc, bus.MemtoReg, bus.RegDst,
                bus.lb_sel, bus.sb_sel, bus.ALUControl, bus.Npc_op});
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ctrl"}, ctrl_vec(), 32'd0);
    chk({tag, ".strobes"}, 32'({bus.pc_en, bus.RegWrite, bus.MemWrite, bus.mem_req}), 32'd0);
    chk({tag, ".flags"}, 32'({bus.illegal, bus.mem_err}), 32'd0);
    chk({tag, ".count"}, bus.instr_count, 32'd0);
  endtask

  // Runs one instruction starting in its FETCH cycle; w = MEM cycles with
  // mem_ready low before it rises (w >= TMO means it never rises).
  task automatic run_instr(input logic [31:0] ins, input int unsigned w);
    exp_t        e;
    int unsigned mc, len;
    logic        to, inmem;
    string       id;
    e   = ref_decode(ins);
    mc  = (w < TMO) ? w + 1 : TMO;
    to  = (e.cls >= 2) && (w >= TMO);
    len = (e.cls == 0) ? 3 : (e.cls == 1) ? 4 : (e.cls == 2 || to) ? 3 + mc : 4 + mc;
    for (int unsigned k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) bus.Instruction = ins;
      inmem = (e.cls >= 2) && (k >= 4) && (k < 4 + mc);
      if (inmem) bus.mem_ready = (w < TMO) && (k == 4 + w);
      else       bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      id = $sformatf("%08h.c%0d", ins, k);
      chk({"ctrl@", id}, ctrl_vec(), (k == 1) ? 32'd0 : 32'(e.ctrl));
      chk({"pc_en@", id}, 32'(bus.pc_en), 32'(k == len));
      chk({"RegWrite@", id}, 32'(bus.RegWrite),
          32'((k == len) && (e.cls == 1 || (e.cls == 3 && !to))));
      chk({"MemWrite@", id}, 32'(bus.MemWrite), 32'((k == len) && e.cls == 2 && !to));
      chk({"mem_req@", id}, 32'(bus.mem_req), 32'(inmem));
      chk({"illegal@", id}, 32'(bus.illegal), 32'(exp_ill));
      chk({"mem_err@", id}, 32'(bus.mem_err), 32'(exp_merr));
      chk({"count@", id}, bus.instr_count, exp_cnt);
      if (k == 2 && e.ill) exp_ill = 1'b1;
      if (k == len) begin
        exp_cnt = exp_cnt + 32'd1;
        if (to) exp_merr = 1'b1;
        bus.Instruction = $urandom;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 14))
      0:  return {6'h00, r[25:6], 6'h21};
      1:  return {6'h00, r[25:6], 6'h23};
      2:  return {6'h00, r[25:6], 6'h08};
      3:  return 32'd0;
      4:  return {6'h0D, r[25:0]};
      5:  return {6'h0F, r[25:0]};
      6:  return {6'h23, r[25:0]};
      7:  return {6'h2B, r[25:0]};
      8:  return {6'h20, r[25:0]};
      9:  return {6'h28, r[25:0]};
      10: return {6'h04, r[25:0]};
      11: return {6'h02, r[25:0]};
      12: return {6'h03, r[25:0]};
      13: return {6'h00, r[25:6], 6'h3F};
      default: return {6'h3F, r[25:0]};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.Instruction = '0;
    bus.mem_ready = 1'b0;
    exp_ill = 1'b0;
    exp_merr = 1'b0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_zero("por");

    // Reset during addu EXEC, then rerun addu from a clean FETCH.
    @(posedge clk); #1 reset = 1'b1;
    bus.Instruction = 32'h00851021;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_zero("rst_mid_exec");
    @(posedge clk); #1 reset = 1'b1;
    run_instr(32'h00851021, 0);

    run_instr(32'h8C820004, 3);    // lw, three wait states
    run_instr(32'hA0820000, 0);    // sb, immediate ready
    run_instr(32'hAC820008, 40);   // sw, memory never answers
    run_instr(32'h10850003, 0);    // beq
    run_instr(32'h0C000010, 0);    // jal
    run_instr(32'h03E00008, 0);    // jr $31

    // Preload the counter to its maximum so the next retirement wraps.
    @(posedge clk); #1;
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1 release dut.r_instr_count;
    exp_cnt = 32'hFFFF_FFFF;
    run_instr(32'hFC000000, 0);
    @(posedge clk); #1;
    chk("wrap.count", bus.instr_count, 32'd0);

    for (int i = 0; i < 40; i++) begin
      int unsigned w;
      w = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
      run_instr(rand_instr(), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
